// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the 16-bit maximal-length Fibonacci LFSR.
// Polynomial x^16+x^15+x^13+x^4+1; the tap mask selects state bits 15, 14, 12 and 3.
package lfsr_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] SEED = 16'h0001;
    localparam logic [WIDTH-1:0] TAP_MASK = 16'hD008;
    localparam int unsigned PERIOD = 65535;

    // Counters must hold a full-period total (at most PERIOD) without wrapping.
    localparam int COUNT_W = $clog2(PERIOD + 1);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [COUNT_W-1:0] count_t;

    function automatic logic feedback(input word_t q);
        return ^(q & TAP_MASK);
    endfunction

    function automatic word_t next_state(input word_t q);
        return {q[WIDTH-2:0], feedback(q)};
    endfunction

endpackage

// File: rtl/lfsr_bit_counter.sv
// Counts feedback ones and zeros over one LFSR period.
// When restart is set, the step loads a fresh count instead of incrementing.
module lfsr_bit_counter
    import lfsr_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   step,
    input  logic   fb,
    input  logic   restart,
    output count_t ones,
    output count_t zeros
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ones  <= '0;
            zeros <= '0;
        end else if (step) begin
            if (restart) begin
                ones  <= count_t'(fb);
                zeros <= count_t'(!fb);
            end else if (fb) begin
                ones  <= ones + count_t'(1);
            end else begin
                zeros <= zeros + count_t'(1);
            end
        end
    end

endmodule

// File: rtl/lfsr.sv
// 16-bit Fibonacci LFSR with a registered wrap tick and per-period feedback bit counters.
// All outputs come straight from flops; reset overrides the shift enable.
module lfsr
    import lfsr_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             sh_en,
    output logic [WIDTH-1:0] Q_out,
    output logic [WIDTH-1:0] ones,
    output logic [WIDTH-1:0] zeros,
    output logic             max_tick_reg
);

    word_t  q_next;
    logic   fb;
    count_t ones_cnt;
    count_t zeros_cnt;

    assign fb     = feedback(Q_out);
    assign q_next = next_state(Q_out);

    // The tick marks the step that lands back on the seed; it also tells the
    // counters that their next step begins a new period.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q_out        <= SEED;
            max_tick_reg <= 1'b0;
        end else if (sh_en) begin
            Q_out        <= q_next;
            max_tick_reg <= (q_next == SEED);
        end
    end

    lfsr_bit_counter u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .step    (sh_en),
        .fb      (fb),
        .restart (max_tick_reg),
        .ones    (ones_cnt),
        .zeros   (zeros_cnt)
    );

    assign ones  = ones_cnt;
    assign zeros = zeros_cnt;

endmodule

// File: tb/tb_lfsr.sv
// Bench for lfsr: a reference model pushes expected outputs per driven cycle,
// which are popped and compared one cycle later; fixed-value checks cover the key points.
module tb_lfsr;

    logic        clk = 1'b0;
    logic        reset;
    logic        sh_en;
    logic [15:0] q_out;
    logic [15:0] ones;
    logic [15:0] zeros;
    logic        max_tick_reg;

    always #5 clk = ~clk;

    lfsr dut (
        .clk          (clk),
        .reset        (reset),
        .sh_en        (sh_en),
        .Q_out        (q_out),
        .ones         (ones),
        .zeros        (zeros),
        .max_tick_reg (max_tick_reg)
    );

    // Expected vector layout: {tick, q, ones, zeros}
    logic [48:0] exp_q[$];

    logic [15:0] m_q;
    logic [15:0] m_ones;
    logic [15:0] m_zeros;
    logic        m_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int seed_hits;
    int zero_hits;
    int steps;
    int pause_at;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e);
        logic fb;
        if (r) begin
            m_q     = 16'h0001;
            m_ones  = 16'h0000;
            m_zeros = 16'h0000;
            m_tick  = 1'b0;
        end else if (e) begin
            fb = m_q[15] ^ m_q[14] ^ m_q[12] ^ m_q[3];
            if (m_tick) begin
                m_ones  = fb ? 16'd1 : 16'd0;
                m_zeros = fb ? 16'd0 : 16'd1;
            end else if (fb) begin
                m_ones = m_ones + 16'd1;
            end else begin
                m_zeros = m_zeros + 16'd1;
            end
            m_q    = {m_q[14:0], fb};
            m_tick = (m_q == 16'h0001);
        end
    endtask

    task automatic apply(input logic r, input logic e, input string tag);
        logic [48:0] exp;
        @(negedge clk);
        reset = r;
        sh_en = e;
        model_step(r, e);
        exp_q.push_back({m_tick, m_q, m_ones, m_zeros});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check({tag, "_q"},     64'(q_out),        64'(exp[47:32]));
        check({tag, "_ones"},  64'(ones),         64'(exp[31:16]));
        check({tag, "_zeros"}, 64'(zeros),        64'(exp[15:0]));
        check({tag, "_tick"},  64'(max_tick_reg), 64'(exp[48]));
        if (!r && e) begin
            if (q_out == 16'h0001) seed_hits++;
            if (q_out == 16'h0000) zero_hits++;
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] q, input logic [15:0] o,
                                 input logic [15:0] z, input logic t);
        check({tag, "_q"},     64'(q_out),        64'(q));
        check({tag, "_ones"},  64'(ones),         64'(o));
        check({tag, "_zeros"}, 64'(zeros),        64'(z));
        check({tag, "_tick"},  64'(max_tick_reg), 64'(t));
    endtask

    initial begin
        logic [15:0] first_seq[4];
        first_seq = '{16'h0002, 16'h0004, 16'h0008, 16'h0011};
        reset = 1'b1;
        sh_en = 1'b0;
        m_q = '0; m_ones = '0; m_zeros = '0; m_tick = 1'b0;

        repeat (5) apply(1'b1, 1'b0, "reset");
        check_outputs("reset_state", 16'h0001, 16'h0000, 16'h0000, 1'b0);

        seed_hits = 0;
        zero_hits = 0;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, "first");
            check("first_seq", 64'(q_out), 64'(first_seq[i]));
        end
        check("first_ones", 64'(ones), 64'd1);
        check("first_zeros", 64'(zeros), 64'd3);

        steps    = 4;
        pause_at = $urandom_range(1000, 60000);
        while (steps < 65535) begin
            if (steps == pause_at) begin
                repeat (10) apply(1'b0, 1'b0, "pause");
            end
            apply(1'b0, 1'b1, "run");
            steps++;
        end
        check_outputs("wrap", 16'h0001, 16'h8000, 16'h7FFF, 1'b1);
        check("seed_once", 64'(seed_hits), 64'd1);
        check("never_zero", 64'(zero_hits), 64'd0);

        repeat (10) apply(1'b0, 1'b0, "pause_tick");
        check_outputs("held_tick", 16'h0001, 16'h8000, 16'h7FFF, 1'b1);

        apply(1'b0, 1'b1, "restart");
        check_outputs("after_wrap", 16'h0002, 16'h0000, 16'h0001, 1'b0);

        repeat (200) apply(1'b0, 1'($urandom_range(0, 1)), "rand");

        apply(1'b1, 1'b1, "mid_reset");
        check_outputs("mid_reset", 16'h0001, 16'h0000, 16'h0000, 1'b0);
        apply(1'b0, 1'b1, "post_reset");
        check("post_reset_first", 64'(q_out), 64'h0002);

        repeat (50) apply(1'b0, 1'($urandom_range(0, 1)), "tail");
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
